// File: rtl/gf180mcu_icg_bank.sv
// Multi-channel latch-based clock-gate bank with per-channel idle hysteresis and a test bypass.
// Optional per-channel activity counters are compiled in with GF180MCU_ICG_ACTIVITY_CNT_EN.
//
// state    | meaning
// ST_OFF   | gate closed, Q parked, ACK low
// ST_ON    | E asserted, clock running
// ST_DRAIN | E dropped, clock kept running for the remaining hold cycles
module gf180mcu_icg_bank #(
   parameter int NCH  = 4,
   parameter int HOLD = 3,
   parameter int POL  = 0,
   parameter int CW   = 16
) (
   input  logic              CLK,
   input  logic              RN,
   input  logic [NCH-1:0]    E,
   input  logic              TE,
`ifdef GF180MCU_ICG_ACTIVITY_CNT_EN
   input  logic              CNT_CLR,
   output logic [NCH*CW-1:0] CNT,
`endif
   output logic [NCH-1:0]    Q,
   output logic [NCH-1:0]    ACK
);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_ON    = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LD  = (HOLD == 0) ? 8'd0 : 8'(HOLD - 1);
   localparam logic       OPEN_LVL = (POL != 0);

   state_t         state_q [NCH];
   state_t         state_d [NCH];
   logic [7:0]     cnt_q   [NCH];
   logic [7:0]     cnt_d   [NCH];
   logic [NCH-1:0] en_r_q;
   logic [NCH-1:0] en_r_d;
   logic [NCH-1:0] gate_d;
   logic [NCH-1:0] gate_l;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ST_OFF: begin
               if (E[i]) state_d[i] = ST_ON;
            end
            ST_ON: begin
               if (!E[i]) begin
                  if (HOLD == 0) begin
                     state_d[i] = ST_OFF;
                  end else begin
                     state_d[i] = ST_DRAIN;
                     cnt_d[i]   = HOLD_LD;
                  end
               end
            end
            ST_DRAIN: begin
               // a re-asserted E wins over an expiring count
               if (E[i]) begin
                  state_d[i] = ST_ON;
                  cnt_d[i]   = 8'd0;
               end else if (cnt_q[i] == 8'd0) begin
                  state_d[i] = ST_OFF;
               end else begin
                  cnt_d[i] = cnt_q[i] - 8'd1;
               end
            end
            default: begin
               state_d[i] = ST_OFF;
               cnt_d[i]   = 8'd0;
            end
         endcase
         en_r_d[i] = (state_d[i] != ST_OFF);
      end
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= ST_OFF;
            cnt_q[i]   <= 8'd0;
         end
         en_r_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         en_r_q <= en_r_d;
      end
   end

   assign ACK    = en_r_q;
   assign gate_d = en_r_q | {NCH{TE}};

   // Transparent in the phase where Q is parked, so d may only move while Q cannot glitch.
   always_latch begin
      if (!RN) begin
         gate_l = '0;
      end else if (CLK == OPEN_LVL) begin
         gate_l = gate_d;
      end
   end

   generate
      if (POL == 0) begin : g_pos
         assign Q = {NCH{CLK}} & gate_l;
      end else begin : g_neg
         assign Q = {NCH{CLK}} | ~gate_l;
      end
   endgenerate

`ifdef GF180MCU_ICG_ACTIVITY_CNT_EN
   logic [CW-1:0] act_q [NCH];
   logic [CW-1:0] act_d [NCH];

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         act_d[i] = act_q[i];
         if (CNT_CLR) begin
            act_d[i] = '0;
         end else if ((en_r_q[i] || TE) && (act_q[i] != {CW{1'b1}})) begin
            act_d[i] = act_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         for (int i = 0; i < NCH; i++) act_q[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) act_q[i] <= act_d[i];
      end
   end

   genvar gi;
   for (gi = 0; gi < NCH; gi++) begin : g_cnt
      assign CNT[gi*CW +: CW] = act_q[gi];
   end
`endif

endmodule

// File: tb/tb_gf180mcu_icg_bank.sv
// Scoreboard bench for gf180mcu_icg_bank: a positive bank with hold 3 and a negative bank with
// hold 0 share the same random E/TE stimulus; a window model predicts ACK, Q phases and counters.
module tb_gf180mcu_icg_bank;
   localparam int HOLD_P = 3;

   logic       clk = 1'b0;
   logic       rn;
   logic       te;
   logic       cnt_clr;
   logic [3:0] e;
   wire  [3:0] qp, qn, ackp, ackn;
`ifdef GF180MCU_ICG_ACTIVITY_CNT_EN
   wire  [15:0] cntp;
   wire  [63:0] cntn;
`endif

   gf180mcu_icg_bank #(.NCH(4), .HOLD(HOLD_P), .POL(0), .CW(4)) dut_p (
      .CLK(clk), .RN(rn), .E(e), .TE(te),
`ifdef GF180MCU_ICG_ACTIVITY_CNT_EN
      .CNT_CLR(cnt_clr), .CNT(cntp),
`endif
      .Q(qp), .ACK(ackp)
   );

   gf180mcu_icg_bank #(.NCH(4), .HOLD(0), .POL(1), .CW(16)) dut_n (
      .CLK(clk), .RN(rn), .E(e), .TE(te),
`ifdef GF180MCU_ICG_ACTIVITY_CNT_EN
      .CNT_CLR(cnt_clr), .CNT(cntn),
`endif
      .Q(qn), .ACK(ackn)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  ackp;
      logic [3:0]  ackn;
      logic [3:0]  qp_hi;
      logic [3:0]  qn_lo;
      logic [15:0] cnt;
   } exp_t;

   exp_t       sbq[$];
   int         checks = 0;
   int         errors = 0;
   bit         done = 1'b0;
   int         age[4] = '{1000, 1000, 1000, 1000};
   int         cnt_m[4] = '{0, 0, 0, 0};
   logic [3:0] prev_ackp = 4'h0;
   int         glitches = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
      end
   endtask

   // Inputs move just after the falling edge; the model then predicts the following rising edge.
   task automatic drive(input logic [3:0] ev, input logic tev, input logic clrv);
      exp_t       x;
      logic [3:0] ap;
      @(negedge clk);
      #1;
      rn = 1'b1;
      e = ev;
      te = tev;
      cnt_clr = clrv;
      for (int i = 0; i < 4; i++) begin
         if (clrv) cnt_m[i] = 0;
         else if (prev_ackp[i] || tev) cnt_m[i] = (cnt_m[i] >= 15) ? 15 : cnt_m[i] + 1;
         age[i] = ev[i] ? 0 : ((age[i] >= 1000) ? 1000 : age[i] + 1);
         ap[i] = (age[i] <= HOLD_P);
         x.cnt[i*4 +: 4] = 4'(cnt_m[i]);
      end
      x.ackp  = ap;
      x.ackn  = ev;
      x.qp_hi = prev_ackp | {4{tev}};
      x.qn_lo = ~(ev | {4{tev}});
      sbq.push_back(x);
      prev_ackp = ap;
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         if (rn === 1'b1 && !done) begin
            #2;
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_empty at %0t: got no entry expected one", $time);
            end else begin
               x = sbq.pop_front();
               chk("ack_p", ackp, x.ackp);
               chk("ack_n", ackn, x.ackn);
               chk("q_p_high", qp, x.qp_hi);
               chk("q_n_high", qn, 4'hF);
`ifdef GF180MCU_ICG_ACTIVITY_CNT_EN
               chk("cnt_p", cntp, x.cnt);
`endif
               @(negedge clk);
               #2;
               chk("q_p_low", qp, 4'h0);
               chk("q_n_low", qn, x.qn_lo);
            end
         end
      end
   end

   time        lastp[4] = '{0, 0, 0, 0};
   time        lastn[4] = '{0, 0, 0, 0};
   logic [3:0] prevp = 4'h0;
   logic [3:0] prevn = 4'hF;

   always @(qp) begin
      for (int i = 0; i < 4; i++) begin
         if (qp[i] !== prevp[i]) begin
            if (rn === 1'b1 && $time > 50 && ($time - lastp[i]) < 5) glitches++;
            lastp[i] = $time;
            prevp[i] = qp[i];
         end
      end
   end

   always @(qn) begin
      for (int i = 0; i < 4; i++) begin
         if (qn[i] !== prevn[i]) begin
            if (rn === 1'b1 && $time > 50 && ($time - lastn[i]) < 5) glitches++;
            lastn[i] = $time;
            prevn[i] = qn[i];
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog at %0t: got no finish expected finish", $time);
      $fatal(1);
   end

   initial begin : stimulus
      logic [3:0] er;
      rn = 1'b0;
      e = 4'hF;
      te = 1'b1;
      cnt_clr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #2;
         chk("rst_q_p_high", qp, 4'h0);
         chk("rst_q_n_high", qn, 4'hF);
         chk("rst_ack_p", ackp, 4'h0);
         chk("rst_ack_n", ackn, 4'h0);
         @(negedge clk);
         #2;
         chk("rst_q_p_low", qp, 4'h0);
         chk("rst_q_n_low", qn, 4'hF);
      end

      repeat (3) drive(4'hF, 1'b1, 1'b0);
      repeat (5) drive(4'hF, 1'b0, 1'b0);
      repeat (6) drive(4'hE, 1'b0, 1'b0);
      repeat (2) drive(4'hC, 1'b0, 1'b0);
      repeat (4) drive(4'hE, 1'b0, 1'b0);
      repeat (6) drive(4'h0, 1'b0, 1'b0);
      repeat (4) drive(4'h0, 1'b1, 1'b0);
      repeat (4) drive(4'h0, 1'b0, 1'b0);
      repeat (3) drive(4'h4, 1'b0, 1'b0);
      repeat (3) drive(4'h0, 1'b0, 1'b0);
      repeat (20) drive(4'h8, 1'b0, 1'b0);
      drive(4'h8, 1'b0, 1'b1);
      repeat (3) drive(4'h8, 1'b0, 1'b0);

      er = 4'h0;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) er = 4'($urandom);
         drive(er, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      end
      repeat (8) drive(4'h0, 1'b0, 1'b0);

      @(posedge clk);
      @(negedge clk);
      #4;
      done = 1'b1;
      chk("sb_drain", sbq.size(), 0);
      chk("no_glitch", glitches, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
